object_draw_engine: RTL and testbench
=====================================

OBJECT_DRAW_ENGINE -- requirements
Module: object_draw_engine

Interface
REQ-001 SHALL have parameter SCREEN_W, default 160, visible screen width in pixels.
REQ-002 SHALL have parameter SCREEN_H, default 120, visible screen height in pixels.
REQ-003 SHALL have parameter BG_COLOUR, default 3'b000, colour written in clear mode.
REQ-004 SHALL have port clk, input, 1, sole clock.
REQ-005 SHALL have port reset, input, 1, asynchronous, active-high reset.
REQ-006 SHALL have port start, input, 1, request to begin one draw job; sampled only in IDLE.
REQ-007 SHALL have port mode, input, 2, job type: 2'b01 clear screen; any other value draws an object.
REQ-008 SHALL have ports obj_x (input, 8, top-left x), obj_y (input, 7, top-left y), obj_w (input, 5, width), obj_h (input, 5, height) and obj_colour (input, 3, fill colour).
REQ-009 SHALL have port busy, output, 1, high while a job is scanning.
REQ-010 SHALL have port done, output, 1, one-cycle completion pulse.
REQ-011 SHALL have ports vga_x (output, 8), vga_y (output, 7) and vga_colour (output, 3), the pixel write address and colour.
REQ-012 SHALL have port vga_plot, output, 1, pixel write enable.

Function
REQ-013 SHALL implement the states IDLE, SCAN and DONE.
REQ-014 IDLE with start=1 SHALL latch mode and the obj_* inputs and go to SCAN.
- Exception: if the latched width or height is 0 (object mode), SHALL go directly to DONE.
REQ-015 start SHALL be ignored in SCAN and DONE, including start coincident with done.
REQ-016 SCAN SHALL emit exactly one pixel per cycle in row-major order.
- Column counter cx runs 0..w-1, then wraps to 0 and increments row counter cy.
- Pixel address is (x0+cx, y0+cy).
REQ-017 The pixel address sums SHALL be computed 1 bit wider than the screen coordinates.
- A pixel with x >= SCREEN_W or y >= SCREEN_H is clipped: vga_plot=0, counting continues.
REQ-018 Clear mode SHALL scan SCREEN_W x SCREEN_H pixels starting at (0,0) with vga_colour=BG_COLOUR, ignoring the obj_* inputs.
REQ-019 After the last pixel of a scan, SHALL go to DONE.
- DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-020 Latency: start accepted on cycle N → first pixel on cycle N+1 → done on cycle N+1+w*h.
- Zero-size job: done on cycle N+1.
- Clear mode: done on cycle N+1+19200.
REQ-021 busy SHALL be 1 exactly in SCAN.
REQ-022 vga_plot SHALL be 1 only in SCAN and only for unclipped pixels.
REQ-023 vga_x, vga_y and vga_colour SHALL hold their last values outside SCAN.
REQ-024 Changes to the obj_* inputs during SCAN SHALL have no effect on the job in progress.

Reset
REQ-025 Asserting reset SHALL force IDLE immediately, including mid-scan.
- Abandons the current job with no done pulse.
REQ-026 Reset values SHALL be: busy=0, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, cx=0, cy=0.
REQ-027 The first start after reset deasserts SHALL be accepted normally.

Structure
REQ-028 A shared package SHALL hold:
- the SCREEN_W and SCREEN_H defaults;
- the mode encodings MODE_OBJECT=2'b00 and MODE_CLEAR=2'b01;
- the engine state encoding.
REQ-029 The 2-D cx/cy counter SHALL be a sub-module, pixel_scan_counter.
- Inputs: width, height, enable, load.
- Outputs: cx, cy, last.

Verification
REQ-030 Object job x=10, y=20, w=3, h=2, colour=3'b101, start on cycle N:
- 6 plots in order (10,20)(11,20)(12,20)(10,21)(11,21)(12,21), cycles N+1..N+6;
- done on N+7.
REQ-031 Clipping job x=158, y=119, w=4, h=2:
- 8 SCAN cycles, plot=1 only for (158,119) and (159,119);
- done after 8 pixels.
REQ-032 Zero-size job w=0, h=5:
- no plot;
- done=1 on cycle N+1;
- busy never 1.
REQ-033 Clear mode:
- 19200 plots, all colour 3'b000;
- last pixel (159,119);
- done on cycle N+19201.
REQ-034 start held high during a w=2, h=2 job and on its done cycle:
- exactly one job runs;
- a new job begins only on the IDLE cycle after done.
REQ-035 reset pulsed on the 3rd SCAN cycle:
- outputs zero immediately, no done pulse;
- a subsequent job runs correctly from cx=0, cy=0.

Source files
------------

// File: rtl/object_draw_engine_pkg.sv
// Shared definitions for the object draw engine: screen defaults, job modes
// and the engine state encoding.
package object_draw_engine_pkg;

    localparam int SCREEN_W_DEFAULT = 160;
    localparam int SCREEN_H_DEFAULT = 120;

    localparam logic [1:0] MODE_OBJECT = 2'b00;
    localparam logic [1:0] MODE_CLEAR  = 2'b01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } engine_state_t;

    // Only the exact clear encoding selects a clear; every other value draws.
    function automatic logic is_clear(input logic [1:0] mode);
        return mode == MODE_CLEAR;
    endfunction

endpackage

// File: rtl/object_draw_engine_scan.sv
// Row-major 2-D pixel counter: cx sweeps 0..width-1, then wraps and bumps cy.
// last flags the final pixel of the width x height rectangle.
module pixel_scan_counter #(
    parameter int CX_W = 8,
    parameter int CY_W = 7
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [CX_W-1:0] width,
    input  logic [CY_W-1:0] height,
    input  logic            enable,
    input  logic            load,
    output logic [CX_W-1:0] cx,
    output logic [CY_W-1:0] cy,
    output logic            last
);

    localparam logic [CX_W-1:0] CX_ONE = CX_W'(1);
    localparam logic [CY_W-1:0] CY_ONE = CY_W'(1);

    logic row_end;

    assign row_end = (cx == width - CX_ONE);
    assign last    = row_end && (cy == height - CY_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cx <= '0;
            cy <= '0;
        end else if (load) begin
            cx <= '0;
            cy <= '0;
        end else if (enable) begin
            if (row_end) begin
                cx <= '0;
                cy <= cy + CY_ONE;
            end else begin
                cx <= cx + CX_ONE;
            end
        end
    end

endmodule

// File: rtl/object_draw_engine.sv
// Rectangle fill / screen clear engine that streams one pixel write per cycle.
//
//   state   | meaning
//   IDLE    | waiting for start; latches the job geometry when it arrives
//   SCAN    | one pixel per cycle, row-major; busy=1
//   DONE    | one-cycle done pulse, start ignored, then back to IDLE
module object_draw_engine
    import object_draw_engine_pkg::*;
#(
    parameter int         SCREEN_W  = SCREEN_W_DEFAULT,
    parameter int         SCREEN_H  = SCREEN_H_DEFAULT,
    parameter logic [2:0] BG_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] mode,
    input  logic [7:0] obj_x,
    input  logic [6:0] obj_y,
    input  logic [4:0] obj_w,
    input  logic [4:0] obj_h,
    input  logic [2:0] obj_colour,
    output logic       busy,
    output logic       done,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       vga_plot
);

    localparam logic [8:0] X_LIM = 9'(SCREEN_W);
    localparam logic [7:0] Y_LIM = 8'(SCREEN_H);

    engine_state_t state;
    logic [7:0]    x0, job_w, cx;
    logic [6:0]    y0, job_h, cy;
    logic [2:0]    job_colour;
    logic          last, zero_job, load;
    logic [8:0]    px;
    logic [7:0]    py;

    assign zero_job = !is_clear(mode) && ((obj_w == 5'd0) || (obj_h == 5'd0));
    assign load     = (state == ST_IDLE) && start && !zero_job;

    pixel_scan_counter #(.CX_W(8), .CY_W(7)) u_scan (
        .clk    (clk),
        .reset  (reset),
        .width  (job_w),
        .height (job_h),
        .enable ((state == ST_SCAN) && !last),
        .load   (load),
        .cx     (cx),
        .cy     (cy),
        .last   (last)
    );

    // One extra bit so objects hanging off the right/bottom edge clip instead of wrapping.
    assign px = {1'b0, x0} + {1'b0, cx};
    assign py = {1'b0, y0} + {1'b0, cy};

    // Address and colour come straight from registers, so they hold outside SCAN.
    assign vga_x      = px[7:0];
    assign vga_y      = py[6:0];
    assign vga_colour = job_colour;
    assign vga_plot   = (state == ST_SCAN) && (px < X_LIM) && (py < Y_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            x0         <= '0;
            y0         <= '0;
            job_w      <= '0;
            job_h      <= '0;
            job_colour <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        if (is_clear(mode)) begin
                            x0         <= '0;
                            y0         <= '0;
                            job_w      <= 8'(SCREEN_W);
                            job_h      <= 7'(SCREEN_H);
                            job_colour <= BG_COLOUR;
                            state      <= ST_SCAN;
                            busy       <= 1'b1;
                        end else if (zero_job) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end else begin
                            x0         <= obj_x;
                            y0         <= obj_y;
                            job_w      <= {3'b000, obj_w};
                            job_h      <= {2'b00, obj_h};
                            job_colour <= obj_colour;
                            state      <= ST_SCAN;
                            busy       <= 1'b1;
                        end
                    end
                end
                ST_SCAN: begin
                    if (last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_object_draw_engine.sv
// Self-checking bench for object_draw_engine: directed jobs plus randomized
// jobs compared against a row-major pixel model computed in the bench.
module tb_object_draw_engine;
    import object_draw_engine_pkg::*;

    localparam int         SW = 160;
    localparam int         SH = 120;
    localparam logic [2:0] BG = 3'b000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [1:0] mode = 2'b00;
    logic [7:0] obj_x = '0;
    logic [6:0] obj_y = '0;
    logic [4:0] obj_w = '0;
    logic [4:0] obj_h = '0;
    logic [2:0] obj_colour = '0;
    logic       busy, done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    int checks = 0;
    int failures = 0;

    object_draw_engine #(.SCREEN_W(SW), .SCREEN_H(SH), .BG_COLOUR(BG)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .mode       (mode),
        .obj_x      (obj_x),
        .obj_y      (obj_y),
        .obj_w      (obj_w),
        .obj_h      (obj_h),
        .obj_colour (obj_colour),
        .busy       (busy),
        .done       (done),
        .vga_x      (vga_x),
        .vga_y      (vga_y),
        .vga_colour (vga_colour),
        .vga_plot   (vga_plot)
    );

    always #5 clk = ~clk;

    task automatic scramble(input logic st);
        mode       = 2'($urandom);
        obj_x      = 8'($urandom);
        obj_y      = 7'($urandom);
        obj_w      = 5'($urandom);
        obj_h      = 5'($urandom);
        obj_colour = 3'($urandom);
        start      = st;
    endtask

    // Called just after a negedge in IDLE; returns just after the negedge of the
    // IDLE cycle following done. With hold_start, start stays high throughout.
    task automatic run_job(input logic [1:0] m, input logic [7:0] x, input logic [6:0] y,
                           input logic [4:0] w, input logic [4:0] h, input logic [2:0] c,
                           input logic hold_start, input string name);
        int ex0, ey0, ew, eh, npix, cyc, idx, ex, ey, plots, exp_plots;
        logic [2:0] ec, hc;
        logic [7:0] hx;
        logic [6:0] hy;
        logic exp_plot, got_done;
        if (m == MODE_CLEAR) begin
            ex0 = 0; ey0 = 0; ew = SW; eh = SH; ec = BG;
        end else begin
            ex0 = int'(x); ey0 = int'(y); ew = int'(w); eh = int'(h); ec = c;
        end
        npix = ew * eh;
        exp_plots = 0;
        for (int r = 0; r < eh; r++)
            for (int k = 0; k < ew; k++)
                if (ex0 + k < SW && ey0 + r < SH) exp_plots++;
        if (npix > 0) begin
            hx = 8'(ex0 + ew - 1); hy = 7'(ey0 + eh - 1); hc = ec;
        end else begin
            hx = vga_x; hy = vga_y; hc = vga_colour;
        end

        mode = m; obj_x = x; obj_y = y; obj_w = w; obj_h = h; obj_colour = c; start = 1'b1;
        @(posedge clk);
        cyc = 0; plots = 0; got_done = 1'b0;
        while (!got_done && cyc < npix + 8) begin
            @(negedge clk);
            cyc++;
            if (done === 1'b1) begin
                got_done = 1'b1;
            end else begin
                idx = cyc - 1;
                ex = 0; ey = 0; exp_plot = 1'b0;
                if (idx < npix) begin
                    ex = ex0 + idx % ew;
                    ey = ey0 + idx / ew;
                    exp_plot = (ex < SW) && (ey < SH);
                end
                checks++;
                if (idx >= npix || busy !== 1'b1 || vga_x !== 8'(ex) || vga_y !== 7'(ey) ||
                    vga_colour !== ec || vga_plot !== exp_plot) begin
                    failures++;
                    if (failures <= 10)
                        $display("FAIL %s pixel %0d: got busy=%b x=%0d y=%0d c=%0d plot=%b, want busy=1 x=%0d y=%0d c=%0d plot=%b (pixels=%0d)",
                                 name, idx, busy, vga_x, vga_y, vga_colour, vga_plot,
                                 8'(ex), 7'(ey), ec, exp_plot, npix);
                end
                if (vga_plot === 1'b1) plots++;
            end
            scramble(hold_start ? 1'b1 : (got_done ? 1'b0 : 1'($urandom)));
        end

        checks++;
        if (!got_done || cyc != npix + 1) begin
            failures++;
            $display("FAIL %s done_latency: got done=%b at cycle %0d, want cycle %0d", name, got_done, cyc, npix + 1);
        end
        checks++;
        if (busy !== 1'b0 || vga_plot !== 1'b0 || vga_x !== hx || vga_y !== hy || vga_colour !== hc) begin
            failures++;
            $display("FAIL %s done_cycle: got busy=%b plot=%b x=%0d y=%0d c=%0d, want busy=0 plot=0 x=%0d y=%0d c=%0d",
                     name, busy, vga_plot, vga_x, vga_y, vga_colour, hx, hy, hc);
        end
        checks++;
        if (plots != exp_plots) begin
            failures++;
            $display("FAIL %s plot_count: got %0d, want %0d", name, plots, exp_plots);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0 || vga_plot !== 1'b0 || vga_x !== hx || vga_y !== hy || vga_colour !== hc) begin
            failures++;
            $display("FAIL %s idle_after_done: got done=%b busy=%b plot=%b x=%0d y=%0d c=%0d, want 0 0 0 %0d %0d %0d",
                     name, done, busy, vga_plot, vga_x, vga_y, vga_colour, hx, hy, hc);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, vga_plot, vga_x, vga_y, vga_colour} !== '0) begin
            failures++;
            $display("FAIL reset_values: got busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, want all 0",
                     busy, done, vga_plot, vga_x, vga_y, vga_colour);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        run_job(MODE_OBJECT, 8'd10, 7'd20, 5'd3, 5'd2, 3'b101, 1'b0, "basic_3x2");
        run_job(MODE_OBJECT, 8'd158, 7'd119, 5'd4, 5'd2, 3'b010, 1'b0, "clip_4x2");
        run_job(MODE_OBJECT, 8'd40, 7'd50, 5'd0, 5'd5, 3'b111, 1'b0, "zero_w");
        run_job(2'b11, 8'd1, 7'd2, 5'd6, 5'd0, 3'b001, 1'b0, "zero_h");
        run_job(2'b10, 8'd250, 7'd125, 5'd31, 5'd31, 3'b110, 1'b0, "far_corner");
    endtask

    task automatic test_clear();
        run_job(MODE_CLEAR, 8'd77, 7'd33, 5'd9, 5'd0, 3'b111, 1'b0, "clear");
    endtask

    task automatic test_back_to_back();
        run_job(MODE_OBJECT, 8'd100, 7'd60, 5'd2, 5'd2, 3'b011, 1'b1, "held_start_2x2");
        run_job(MODE_OBJECT, 8'd3, 7'd4, 5'd3, 5'd3, 3'b100, 1'b0, "after_held_start");
    endtask

    task automatic test_reset_mid_scan();
        mode = MODE_OBJECT; obj_x = 8'd5; obj_y = 7'd6; obj_w = 5'd4; obj_h = 5'd3;
        obj_colour = 3'b011; start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, vga_plot, vga_x, vga_y, vga_colour} !== '0) begin
            failures++;
            $display("FAIL reset_mid_scan_outputs: got busy=%b done=%b plot=%b x=%0d y=%0d c=%0d, want all 0",
                     busy, done, vga_plot, vga_x, vga_y, vga_colour);
        end
        @(negedge clk);
        reset = 1'b0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_mid_scan_no_done: got done=%b busy=%b, want 0 0", done, busy);
            end
        end
        run_job(MODE_OBJECT, 8'd30, 7'd40, 5'd5, 5'd2, 3'b110, 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [1:0] m;
        for (int i = 0; i < 25; i++) begin
            case ($urandom_range(0, 2))
                0: m = 2'b00;
                1: m = 2'b10;
                default: m = 2'b11;
            endcase
            run_job(m, 8'($urandom), 7'($urandom),
                    5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 3'($urandom),
                    (i < 24) ? 1'($urandom) : 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_clear();
        test_back_to_back();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
